// File: rtl/pdes_prio_q_pkg.sv
// Shared definitions for the PDES priority queue: default widths, op select
// encodings and the unsigned key comparator used by every cell.
package pdes_pq_pkg;

  localparam int PQ_DW = 16;
  localparam int PQ_KW = 16;

  // Op select is {deq_fire, enq_fire}, so the top can build it by concatenation.
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_BOTH = 2'b11;

  function automatic logic key_lt(input logic [63:0] a, input logic [63:0] b, input int kw);
    logic [63:0] m;
    m = (kw >= 64) ? '1 : ((64'd1 << kw) - 64'd1);
    return (a & m) < (b & m);
  endfunction

endpackage

// File: rtl/pdes_prio_q_if.sv
// Enqueue/dequeue handshake and status bundle for pdes_prio_q.
// flush exists only when PDES_PQ_FLUSH_EN is defined.
interface pdes_prio_q_if #(
  parameter int DW    = pdes_pq_pkg::PQ_DW,
  parameter int DEPTH = 16
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic            enq_valid;
  logic            enq_ready;
  logic [DW-1:0]   enq_data;
  logic            deq_valid;
  logic            deq_ready;
  logic [DW-1:0]   deq_data;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
`ifdef PDES_PQ_FLUSH_EN
  logic            flush;
`endif

  modport master (
    output enq_valid, enq_data, deq_ready,
`ifdef PDES_PQ_FLUSH_EN
    output flush,
`endif
    input  enq_ready, deq_valid, deq_data, count, full, empty
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
`ifdef PDES_PQ_FLUSH_EN
    input  flush,
`endif
    output enq_ready, deq_valid, deq_data, count, full, empty
  );

endinterface

// File: rtl/pdes_prio_q_cell.sv
// One slot of the systolic sorted array: computes its "stays ahead of new
// entry" bit and its next {valid, data} from its own and neighbour slots.
module pdes_pq_cell
  import pdes_pq_pkg::*;
#(
  parameter int DW      = PQ_DW,
  parameter int KW      = PQ_KW,
  parameter bit IS_HEAD = 1'b0
) (
  input  logic [1:0]    i_op,
  input  logic          i_own_v,
  input  logic [DW-1:0] i_own_d,
  input  logic          i_lft_v,
  input  logic [DW-1:0] i_lft_d,
  input  logic          i_lft_g,
  input  logic          i_rgt_v,
  input  logic [DW-1:0] i_rgt_d,
  input  logic          i_rgt_g,
  input  logic [DW-1:0] i_new_d,
  output logic          o_g,
  output logic          o_nxt_v,
  output logic [DW-1:0] o_nxt_d
);

  logic [63:0] w_key_new;
  logic [63:0] w_key_own;
  logic        w_g;

  assign w_key_new = 64'(i_new_d[KW-1:0]);
  assign w_key_own = 64'(i_own_d[KW-1:0]);
  // Equal keys stay ahead of the newcomer, giving FIFO order among ties.
  assign w_g = i_own_v && !key_lt(w_key_new, w_key_own, KW);
  assign o_g = w_g;

  always_comb begin
    o_nxt_v = i_own_v;
    o_nxt_d = i_own_d;
    case (i_op)
      OP_ENQ: begin
        if (w_g) begin
          o_nxt_v = i_own_v;
          o_nxt_d = i_own_d;
        end else if (IS_HEAD || i_lft_g) begin
          o_nxt_v = 1'b1;
          o_nxt_d = i_new_d;
        end else begin
          o_nxt_v = i_lft_v;
          o_nxt_d = i_lft_d;
        end
      end
      OP_DEQ: begin
        o_nxt_v = i_rgt_v;
        o_nxt_d = i_rgt_d;
      end
      OP_BOTH: begin
        // Insert into the array as it looks after the head has been popped.
        if (i_rgt_g) begin
          o_nxt_v = i_rgt_v;
          o_nxt_d = i_rgt_d;
        end else if (IS_HEAD || w_g) begin
          o_nxt_v = 1'b1;
          o_nxt_d = i_new_d;
        end else begin
          o_nxt_v = i_own_v;
          o_nxt_d = i_own_d;
        end
      end
      default: begin
        o_nxt_v = i_own_v;
        o_nxt_d = i_own_d;
      end
    endcase
  end

endmodule

// File: rtl/pdes_prio_q.sv
// Registered systolic priority queue: smallest key at cell 0, one enqueue and
// one dequeue per cycle. Optional synchronous flush under PDES_PQ_FLUSH_EN.
module pdes_prio_q
  import pdes_pq_pkg::*;
#(
  parameter int DW    = PQ_DW,
  parameter int KW    = PQ_KW,
  parameter int DEPTH = 16
) (
  input  logic           CLK,
  input  logic           rst_n,
  pdes_prio_q_if.slave   bus
);

  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]         r_v;
  logic [DEPTH-1:0][DW-1:0] r_d;
  logic [CNTW-1:0]          r_cnt;
  logic                     r_full;
  logic                     r_empty;

  logic [DEPTH-1:0]         w_nv;
  logic [DEPTH-1:0][DW-1:0] w_nd;
  logic                     w_enq_fire;
  logic                     w_deq_fire;
  logic [1:0]               w_op;
  logic [CNTW-1:0]          w_cnt_nxt;

  assign w_enq_fire = bus.enq_valid && !r_full;
  assign w_deq_fire = bus.deq_ready && !r_empty;
  assign w_op       = {w_deq_fire, w_enq_fire};

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic          w_g;
    logic          w_lv, w_lg, w_rv, w_rg;
    logic [DW-1:0] w_ld, w_rd;

    if (i == 0) begin : g_lft
      assign w_lv = 1'b0;
      assign w_ld = '0;
      assign w_lg = 1'b0;
    end else begin : g_lft
      assign w_lv = r_v[i-1];
      assign w_ld = r_d[i-1];
      assign w_lg = g_cell[i-1].w_g;
    end

    if (i == DEPTH - 1) begin : g_rgt
      assign w_rv = 1'b0;
      assign w_rd = '0;
      assign w_rg = 1'b0;
    end else begin : g_rgt
      assign w_rv = r_v[i+1];
      assign w_rd = r_d[i+1];
      assign w_rg = g_cell[i+1].w_g;
    end

    pdes_pq_cell #(
      .DW      (DW),
      .KW      (KW),
      .IS_HEAD (i == 0)
    ) u_cell (
      .i_op    (w_op),
      .i_own_v (r_v[i]),
      .i_own_d (r_d[i]),
      .i_lft_v (w_lv),
      .i_lft_d (w_ld),
      .i_lft_g (w_lg),
      .i_rgt_v (w_rv),
      .i_rgt_d (w_rd),
      .i_rgt_g (w_rg),
      .i_new_d (bus.enq_data),
      .o_g     (w_g),
      .o_nxt_v (w_nv[i]),
      .o_nxt_d (w_nd[i])
    );
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case (w_op)
      OP_ENQ:  w_cnt_nxt = r_cnt + CNTW'(1);
      OP_DEQ:  w_cnt_nxt = r_cnt - CNTW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
`ifdef PDES_PQ_FLUSH_EN
      if (bus.flush) begin
        r_v     <= '0;
        r_d     <= '0;
        r_cnt   <= '0;
        r_full  <= 1'b0;
        r_empty <= 1'b1;
      end else
`endif
      begin
        r_v     <= w_nv;
        r_d     <= w_nd;
        r_cnt   <= w_cnt_nxt;
        r_full  <= (w_cnt_nxt == CNTW'(DEPTH));
        r_empty <= (w_cnt_nxt == '0);
      end
    end
  end

  assign bus.enq_ready = !r_full;
  assign bus.deq_valid = !r_empty;
  assign bus.deq_data  = r_d[0];
  assign bus.count     = r_cnt;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;

endmodule

// File: tb/tb_pdes_prio_q.sv
// Randomised scoreboard bench for pdes_prio_q (DW=16, KW=8 so payload ties are visible).
module tb_pdes_prio_q;

  localparam int DW    = 16;
  localparam int KW    = 8;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  pdes_prio_q_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  pdes_prio_q #(.DW(DW), .KW(KW), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mq[$];   // reference contents, head first
  logic [DW-1:0] sb[$];   // expected popped entries
  int errs = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stable insert: goes behind every entry whose key is <= its own.
  task automatic model_ins(input logic [DW-1:0] d);
    int p = mq.size();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i][KW-1:0] > d[KW-1:0]) begin p = i; break; end
    mq.insert(p, d);
  endtask

  task automatic step(input bit ev, input logic [DW-1:0] ed, input bit dr);
    bit fe, fd;
    bus.enq_valid = ev;
    bus.enq_data  = ed;
    bus.deq_ready = dr;
    fe = ev && (mq.size() < DEPTH);
    fd = dr && (mq.size() > 0);
    if (fd) sb.push_back(mq[0]);
    @(posedge CLK);
    if (fd) void'(mq.pop_front());
    if (fe) model_ins(ed);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_deq_valid"}, 32'(bus.deq_valid), 0);
    chk({tag, "_deq_data"}, 32'(bus.deq_data), 0);
    chk({tag, "_enq_ready"}, 32'(bus.enq_ready), 1);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("enq_ready", 32'(bus.enq_ready), 32'(mq.size() != DEPTH));
      chk("deq_valid", 32'(bus.deq_valid), 32'(mq.size() != 0));
      if (mq.size() > 0) chk("head", 32'(bus.deq_data), 32'(mq[0]));
      if (bus.deq_valid && bus.deq_ready) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL pop actual=%0h expected=none at %0t", bus.deq_data, $time);
        end else begin
          chk("pop", 32'(bus.deq_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic drain();
    repeat (DEPTH + 1) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_data  = '0;
    bus.deq_ready = 1'b0;
`ifdef PDES_PQ_FLUSH_EN
    bus.flush = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    reset_checks("rst");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Order 30,10,20: head sequence 30,10,10 then pops 10,20,30
    step(1'b1, 16'd30, 1'b0);
    step(1'b1, 16'd10, 1'b0);
    step(1'b1, 16'd20, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Fill with 16..1, then a key-0 enqueue while full must be ignored
    for (int k = 16; k >= 1; k--) step(1'b1, DW'(k), 1'b0);
    step(1'b1, 16'd0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("full_head", 32'(bus.deq_data), 1);
    drain();

    // Simultaneous enq+deq on {5,9} with keys 7 and 3, then on {5} with 8
    step(1'b1, 16'd5, 1'b0); step(1'b1, 16'd9, 1'b0);
    step(1'b1, 16'd7, 1'b1); step(1'b0, '0, 1'b0);
    drain();
    step(1'b1, 16'd5, 1'b0); step(1'b1, 16'd9, 1'b0);
    step(1'b1, 16'd3, 1'b1); step(1'b0, '0, 1'b0);
    chk("both_head3", 32'(bus.deq_data), 3);
    drain();
    step(1'b1, 16'd5, 1'b0);
    step(1'b1, 16'd8, 1'b1); step(1'b0, '0, 1'b0);
    chk("both_single", 32'(bus.deq_data), 8);
    drain();

    // Equal keys with differing payloads leave in arrival order
    step(1'b1, 16'hA104, 1'b0);
    step(1'b1, 16'h0009, 1'b0);
    step(1'b1, 16'hB204, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);

    // Random traffic: enqueue-heavy phase reaches full, then dequeue-heavy
    for (int n = 0; n < 600; n++) begin
      int eb = (n < 300) ? 70 : 30;
      step($urandom_range(0, 99) < eb, {8'($urandom), 8'($urandom_range(0, 15))},
           $urandom_range(0, 99) < (100 - eb));
    end
    drain();

    // Asynchronous reset in the middle of a burst of 6 entries
    for (int k = 0; k < 6; k++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    bus.enq_valid = 1'b1;
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    mq.delete();
    sb.delete();
    #1;
    reset_checks("midrst");
    @(posedge CLK);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(1'b0, '0, 1'b0);

`ifdef PDES_PQ_FLUSH_EN
    for (int k = 0; k < 4; k++) step(1'b1, DW'(k + 2), 1'b0);
    bus.flush = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_data = 16'd1;
    bus.deq_ready = 1'b0;
    @(posedge CLK);
    mq.delete();
    #1;
    bus.flush = 1'b0;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_enq_ready", 32'(bus.enq_ready), 1);
    step(1'b0, '0, 1'b0);
`endif

    step(1'b0, '0, 1'b0);
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pdes_prio_q.md
Name: pdes_prio_q

Overview:
- Parametrised, fully registered priority queue for the PDES event scheduler. Supersedes the fixed 16-bit, 15-entry pipelined heap.
- Holds up to DEPTH events as a systolic sorted array, smallest key at the head. Key is the low KW bits of each entry.
- Valid/ready handshakes on both sides; full and empty flags.
- Enqueue and dequeue are both accepted in the same cycle, so an event core can pop the next event and push a newly generated one back-to-back.

Parameters:
- DW, 16, entry width in bits (timestamp key plus payload)
- KW, 16, key width; key = data[KW-1:0]; 1 <= KW <= DW
- DEPTH, 16, maximum entry count; >= 2
- CNTW, $clog2(DEPTH+1), width of count (derived; not overridden)

Ports:
- CLK  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- enq_valid  in  1  enq_data is offered
- enq_ready  out  1  queue accepts an enqueue this cycle
- enq_data  in  DW  entry to insert
- deq_valid  out  1  head entry is available
- deq_ready  in  1  consumer pops the head this cycle
- deq_data  out  DW  current head (minimum key)
- count  out  CNTW  number of stored entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (async, rst_n low): all cell valid bits 0, cell data 0, count 0.
  - empty=1, full=0, deq_valid=0, deq_data=0, enq_ready=1.
  - Mid-operation reset discards all contents immediately.
- Storage: cells c[0..DEPTH-1], each holding {valid, data}.
  - Invariants: valid cells are contiguous from c[0]; keys are non-decreasing with index.
- Handshake:
  - enq fires when enq_valid && enq_ready; enq_ready = !full (registered-derived, no combinational path from deq_ready).
  - deq fires when deq_valid && deq_ready; deq_valid = !empty; deq_data = c[0].data, driven directly from the register.
- Insert rule: g[i] = c[i].valid && key(c[i]) <= key(new).
  - Strict less-than displacement gives FIFO order among equal keys.
- Enq only: cell i takes
  - c[i] if g[i];
  - new if !g[i] && (i==0 || g[i-1]);
  - otherwise c[i-1] (shift toward tail).
  - count+1.
- Deq only: c[i] <= c[i+1]; c[DEPTH-1] becomes invalid with data 0; count-1.
- Enq+deq same cycle: insertion into the shifted array. Cell i takes
  - c[i+1] if g[i+1];
  - new if !g[i+1] && (i==0 || g[i]);
  - otherwise c[i].
  - count unchanged.
  - Must work at count==1: the result is the new entry alone.
  - Cannot occur on full (enq_ready low) or on empty (deq_valid low).
- Latency: an accepted entry is visible at deq_data on the next cycle if its key is the new minimum. One op of each kind per cycle, no bubbles.
- Ignored inputs: enq_valid while full and deq_ready while empty are ignored, with no state change.
- Arithmetic: key compare is unsigned over KW bits. Payload bits [DW-1:KW] are never compared.
- count, full and empty are registered and updated in the same cycle as the cell array.

Optional Feature:
- Macro PDES_PQ_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit). When sampled high at posedge, all cells are invalidated and count goes to 0.
  - flush takes priority over enq/deq in the same cycle; those handshakes are dropped.
  - enq_ready=1 in the following cycle.
- Undefined: no flush port; contents are cleared only by rst_n.

Decomposition:
- Package pdes_pq_pkg holds:
  - default DW and KW localparams;
  - function key_lt(a, b, KW), the shared unsigned comparator;
  - localparam encodings for the op select: OP_HOLD, OP_ENQ, OP_DEQ, OP_BOTH.
- Sub-module pdes_pq_cell: one array slot.
  - Inputs: op, own/left/right neighbour {valid, data}, new entry.
  - Produces its g bit and next state.
  - Instantiated DEPTH times in a generate loop.
  - Boundary cells tie off the missing neighbour as invalid.

Test Plan:
- Reset, then enq keys 30,10,20 on consecutive cycles: deq_data reads 30, 10, 10; count=3. Then deq 3 times: data 10, 20, 30; empty=1.
- Fill DEPTH=16 with keys 16..1: full=1, enq_ready=0. An enq of key 0 while full is ignored: head stays 1, count 16.
- With queue {5,9}, enq key 7 and deq in the same cycle: popped 5; next head 7; contents {7,9}; count 2.
- Same as above with enq key 3: new head 3 in the next cycle; count 2. With count==1 {5}, enq 8 plus deq gives {8}.
- Equal keys: enq {key 4, payload A} then {key 4, payload B} (DW>KW). Deqs return A then B.
- Assert rst_n low mid-burst with 6 entries: outputs return to reset values immediately. With PDES_PQ_FLUSH_EN, flush plus simultaneous enq gives count 0.
